// File: rtl/addsub_pkg.sv
// Shared types for the pipelined add/subtract block.
//   op_e   : operation code carried with each beat
//   is_sub : true for the subtracting operations (SUB, SUB_SAT)
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ADD_SAT = 2'b10,
    OP_SUB_SAT = 2'b11
  } op_e;

  function automatic logic is_sub(input op_e op);
    return (op == OP_SUB) || (op == OP_SUB_SAT);
  endfunction

endpackage

// File: rtl/addsub_pipe_sat_if.sv
// Handshake/data bundle for addsub_pipe_sat.
//   in_valid/in_ready   : operand beat handshake (op, a, b, ci)
//   out_valid/out_ready : result beat handshake (res, co, ovf)
// master = the side producing operands and consuming results,
// slave  = the arithmetic block.
interface addsub_pipe_sat_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, op, a, b, ci, out_ready,
    input  in_ready, out_valid, res, co, ovf
  );

  modport slave (
    input  in_valid, op, a, b, ci, out_ready,
    output in_ready, out_valid, res, co, ovf
  );
endinterface

// File: rtl/addsub_seg.sv
// One carry-chain segment: SEG-bit a + b + cin.
//   a, b : segment operands (b already inverted for subtraction)
//   cin  : carry into the segment
//   sum  : SEG-bit segment sum
//   cout : carry out of the segment
module addsub_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/addsub_pipe_sat.sv
// Pipelined add/subtract with carry/borrow in/out and optional saturation.
// The carry chain is cut into STAGES segments of WIDTH/STAGES bits; stage k
// adds segment k using the carry registered by stage k-1.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, discards all in-flight beats
//   bus   : slave side of addsub_pipe_sat_if (operand in, result out)
// Constraints: WIDTH >= 2, 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0.
module addsub_pipe_sat
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  addsub_pipe_sat_if.slave bus
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage registers. a/bx travel with the beat so later stages can add
  // their segment and the final stage can derive signed overflow; sum
  // accumulates the finished low segments.
  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] carry_reg;
  logic [WIDTH-1:0]  a_reg   [STAGES];
  logic [WIDTH-1:0]  bx_reg  [STAGES];
  logic [WIDTH-1:0]  sum_reg [STAGES];
  op_e               op_reg  [STAGES];

  // Per-stage inputs (from the bus for stage 0, from stage k-1 otherwise)
  logic              vin_w      [STAGES];
  op_e               op_in_w    [STAGES];
  logic [WIDTH-1:0]  a_in_w     [STAGES];
  logic [WIDTH-1:0]  bx_in_w    [STAGES];
  logic              cin_w      [STAGES];
  logic [WIDTH-1:0]  sum_in_w   [STAGES];
  logic [WIDTH-1:0]  sum_next_w [STAGES];
  logic              cout_w     [STAGES];

  logic [STAGES-1:0] adv;

  // A stage may load when it is empty or its successor is moving on.
  // Evaluated from the output backwards so bubbles collapse.
  always_comb begin
    adv       = '0;
    adv[LAST] = !valid_reg[LAST] || bus.out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k] = !valid_reg[k] || adv[k+1];
    end
  end

  assign bus.in_ready = adv[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << (gi * SEG);

    logic [SEG-1:0] seg_sum;

    if (gi == 0) begin : g_head
      // Subtraction is a + ~b + ~ci; the raw carry is later inverted to a borrow.
      assign vin_w[gi]    = bus.in_valid;
      assign op_in_w[gi]  = bus.op;
      assign a_in_w[gi]   = bus.a;
      assign bx_in_w[gi]  = is_sub(bus.op) ? ~bus.b : bus.b;
      assign cin_w[gi]    = is_sub(bus.op) ? ~bus.ci : bus.ci;
      assign sum_in_w[gi] = '0;
    end else begin : g_body
      assign vin_w[gi]    = valid_reg[gi-1];
      assign op_in_w[gi]  = op_reg[gi-1];
      assign a_in_w[gi]   = a_reg[gi-1];
      assign bx_in_w[gi]  = bx_reg[gi-1];
      assign cin_w[gi]    = carry_reg[gi-1];
      assign sum_in_w[gi] = sum_reg[gi-1];
    end

    addsub_seg #(
      .SEG (SEG)
    ) u_seg (
      .a    (a_in_w[gi][gi*SEG +: SEG]),
      .b    (bx_in_w[gi][gi*SEG +: SEG]),
      .cin  (cin_w[gi]),
      .sum  (seg_sum),
      .cout (cout_w[gi])
    );

    // Splice this segment into the partial sum handed down the pipe
    assign sum_next_w[gi] = (sum_in_w[gi] & ~SEG_MASK) | (WIDTH'(seg_sum) << (gi * SEG));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      carry_reg <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_reg[k]   <= '0;
        bx_reg[k]  <= '0;
        sum_reg[k] <= '0;
        op_reg[k]  <= OP_ADD;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          valid_reg[k] <= vin_w[k];
          // Payload only moves with a real beat; bubbles leave it untouched
          if (vin_w[k]) begin
            a_reg[k]     <= a_in_w[k];
            bx_reg[k]    <= bx_in_w[k];
            sum_reg[k]   <= sum_next_w[k];
            carry_reg[k] <= cout_w[k];
            op_reg[k]    <= op_in_w[k];
          end
        end
      end
    end
  end

  // Output stage: co/ovf always describe the raw sum, saturation only
  // rewrites res. Everything here is a function of the last stage's
  // registers, so it holds still while the output is stalled.
  logic             co_w;
  logic [WIDTH-1:0] res_w;

  assign co_w = is_sub(op_reg[LAST]) ? ~carry_reg[LAST] : carry_reg[LAST];

  always_comb begin
    res_w = sum_reg[LAST];
    if (co_w && (op_reg[LAST] == OP_ADD_SAT)) begin
      res_w = '1;
    end else if (co_w && (op_reg[LAST] == OP_SUB_SAT)) begin
      res_w = '0;
    end
  end

  assign bus.out_valid = valid_reg[LAST];
  assign bus.res       = res_w;
  assign bus.co        = co_w;
  assign bus.ovf       = (a_reg[LAST][WIDTH-1] == bx_reg[LAST][WIDTH-1]) &&
                         (sum_reg[LAST][WIDTH-1] != a_reg[LAST][WIDTH-1]);

endmodule

// File: tb/tb_addsub_pipe_sat.sv
// Scoreboard bench for addsub_pipe_sat: a directed WIDTH=8/STAGES=2 instance
// plus WIDTH=16/STAGES=4 and WIDTH=8/STAGES=1 instances driven randomly.
module tb_addsub_pipe_sat;
  import addsub_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sw_rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Whole-width reference: returns {ovf, co, res} with res in the low 16 bits
  function automatic logic [17:0] model(input int w, input logic [1:0] op,
                                        input logic [15:0] a, input logic [15:0] b,
                                        input logic ci);
    logic [15:0] mask, am, bx, raw, r;
    logic [16:0] full;
    logic        sub, carry, co, ov;
    mask  = 16'((17'd1 << w) - 17'd1);
    sub   = op[0];
    am    = a & mask;
    bx    = (sub ? ~b : b) & mask;
    full  = {1'b0, am} + {1'b0, bx} + {16'd0, sub ? ~ci : ci};
    raw   = full[15:0] & mask;
    carry = full[w];
    co    = sub ? ~carry : carry;
    ov    = (am[w-1] == bx[w-1]) && (raw[w-1] != am[w-1]);
    r     = raw;
    if (op == 2'b10 && co) r = mask;
    if (op == 2'b11 && co) r = 16'd0;
    return {ov, co, r};
  endfunction

  // ---------------- directed instance: WIDTH=8, STAGES=2 ----------------
  addsub_pipe_sat_if #(.WIDTH(8)) mif ();
  addsub_pipe_sat #(.WIDTH(8), .STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif.slave)
  );

  logic [9:0] exp_q[$];   // {ovf, co, res}
  int         acc_q[$];
  int         acc_cnt = 0;
  int         beat_n = 0;
  int         stale_cnt = 0;
  logic       lat_chk = 1'b0;

  typedef struct {
    op_e        op;
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] r;
    logic       co, ov;
  } vec_t;
  vec_t vecs[11];

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one beat; expectation enters the scoreboard when the handshake is seen
  task automatic send(input op_e o, input logic [7:0] av, input logic [7:0] bv,
                      input logic civ, input logic [9:0] e);
    mif.op = o; mif.a = av; mif.b = bv; mif.ci = civ; mif.in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mif.in_ready) begin
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        acc_cnt++;
        @(posedge clk);
        #1;
        mif.in_valid = 1'b0;
        return;
      end
    end
    total++; bad++;
    $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, expected 1");
    mif.in_valid = 1'b0;
  endtask

  // Monitor: pop and compare on every output transfer
  always @(negedge clk) begin : mon
    logic [9:0] e;
    int t;
    if (rst_n === 1'b1 && mif.out_valid && mif.out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++; stale_cnt++;
        $display("FAIL unexpected_beat: got res=%02h with empty scoreboard, expected no beat", mif.res);
      end else begin
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        chk("result", {22'd0, mif.ovf, mif.co, mif.res}, {22'd0, e});
        if (lat_chk) chk("latency", cyc - t, 2);
        $display("beat %0d res=%02h co=%0b ovf=%0b latency=%0d", beat_n, mif.res, mif.co, mif.ovf, cyc - t);
        beat_n++;
      end
    end
  end

  // Stall monitor: a held output must not move
  logic       stall_prev = 1'b0;
  logic [9:0] stall_val;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && stall_prev)
      chk("stall_hold", {21'd0, mif.out_valid, mif.ovf, mif.co, mif.res}, {21'd0, 1'b1, stall_val});
    stall_prev <= (rst_n === 1'b1) && mif.out_valid && !mif.out_ready;
    stall_val  <= {mif.ovf, mif.co, mif.res};
  end

  // ---------------- random sweep instances ----------------
  localparam int NBEATS = 10000;

  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int W = (gi == 0) ? 16 : 8;
    localparam int S = (gi == 0) ? 4 : 1;

    addsub_pipe_sat_if #(.WIDTH(W)) sif ();
    addsub_pipe_sat #(.WIDTH(W), .STAGES(S)) sdut (
      .clk   (clk),
      .rst_n (sw_rst_n),
      .bus   (sif.slave)
    );

    logic [17:0] sq[$];
    int          sq_t[$];
    logic        done = 1'b0;

    initial begin : drv
      int          sent;
      logic        accepted;
      logic [15:0] ra, rb;
      logic [1:0]  ro;
      logic        rc;
      sif.in_valid = 1'b0; sif.op = OP_ADD; sif.a = '0; sif.b = '0; sif.ci = 1'b0;
      sif.out_ready = 1'b0;
      sent = 0; ra = '0; rb = '0; ro = '0; rc = 1'b0;
      wait (sw_rst_n === 1'b1);
      @(posedge clk);
      #1;
      for (int c = 0; c < 40000 && sent < NBEATS; c++) begin
        if (!sif.in_valid && $urandom_range(0, 3) != 0) begin
          ra = 16'($urandom); rb = 16'($urandom); ro = 2'($urandom); rc = 1'($urandom);
          sif.op = op_e'(ro); sif.a = ra[W-1:0]; sif.b = rb[W-1:0]; sif.ci = rc;
          sif.in_valid = 1'b1;
        end
        sif.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        accepted = 1'b0;
        if (sif.in_valid && sif.in_ready) begin
          sq.push_back(model(W, ro, ra, rb, rc));
          sq_t.push_back(cyc);
          sent++;
          accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        if (accepted) sif.in_valid = 1'b0;
      end
      sif.in_valid = 1'b0;
      sif.out_ready = 1'b1;
      for (int c = 0; c < 200 && sq.size() != 0; c++) @(posedge clk);
      chk("sweep_sent", sent, NBEATS);
      chk("sweep_drain", sq.size(), 0);
      $display("sweep W=%0d S=%0d: %0d beats issued", W, S, sent);
      done = 1'b1;
    end

    always @(negedge clk) begin : smon
      logic [17:0] e;
      int t;
      if (sw_rst_n === 1'b1 && sif.out_valid && sif.out_ready) begin
        if (sq.size() == 0) begin
          total++; bad++;
          $display("FAIL sweep_unexpected W=%0d S=%0d: got res=%0h, expected no beat", W, S, sif.res);
        end else begin
          e = sq.pop_front();
          t = sq_t.pop_front();
          chk("sweep_result", {14'd0, sif.ovf, sif.co, 16'(sif.res)}, {14'd0, e});
          chk("sweep_min_latency", 32'((cyc - t) >= S), 1);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    vecs[0]  = '{OP_SUB,     8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{OP_SUB,     8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2]  = '{OP_SUB_SAT, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{OP_ADD,     8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{OP_ADD_SAT, 8'hFF, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5]  = '{OP_ADD,     8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6]  = '{OP_SUB,     8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[7]  = '{OP_SUB,     8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[8]  = '{OP_ADD_SAT, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[9]  = '{OP_SUB_SAT, 8'h03, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{OP_ADD,     8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    mif.in_valid = 1'b0; mif.op = OP_ADD; mif.a = '0; mif.b = '0; mif.ci = 1'b0;
    mif.out_ready = 1'b0;
    rst_n = 1'b0; sw_rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_out_valid", mif.out_valid, 0);
    chk("reset_res", mif.res, 0);
    chk("reset_co", mif.co, 0);
    chk("reset_ovf", mif.ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; sw_rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", mif.in_ready, 1);
    @(posedge clk);
    #1;

    // Isolated beats: value and latency
    mif.out_ready = 1'b1;
    lat_chk = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci, {vecs[i].ov, vecs[i].co, vecs[i].r});
      idle(3);
    end

    // Back-to-back beats at full rate
    for (int i = 0; i < 11; i++)
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci, {vecs[i].ov, vecs[i].co, vecs[i].r});
    idle(4);
    chk("throughput_drain", exp_q.size(), 0);

    // Backpressure: pipe fills after two beats, then holds for five cycles
    lat_chk = 1'b0;
    mif.out_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        send(OP_SUB, 8'd10, 8'd1, 1'b0, {2'b00, 8'd9});
        send(OP_SUB, 8'd20, 8'd2, 1'b0, {2'b00, 8'd18});
        send(OP_SUB, 8'd30, 8'd3, 1'b0, {2'b00, 8'd27});
        send(OP_SUB, 8'd40, 8'd4, 1'b0, {2'b00, 8'd36});
      end
      begin
        for (int k = 0; k < 50 && acc_cnt < base + 2; k++) @(negedge clk);
        @(negedge clk);
        chk("in_ready_full", mif.in_ready, 0);
        chk("accepts_before_full", acc_cnt - base, 2);
        repeat (5) @(posedge clk);
        #1;
        mif.out_ready = 1'b1;
      end
    join
    idle(6);
    chk("backpressure_drain", exp_q.size(), 0);

    // Reset with two beats in flight
    mif.out_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h02, 1'b0, {2'b00, 8'h03});
    send(OP_SUB, 8'h09, 8'h04, 1'b0, {2'b00, 8'h05});
    chk("pre_reset_out_valid", mif.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", mif.out_valid, 0);
    chk("midreset_res", mif.res, 0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mif.out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_midreset", mif.in_ready, 1);
    idle(6);
    chk("no_stale_beat", stale_cnt, 0);
    lat_chk = 1'b1;
    send(OP_SUB_SAT, 8'h03, 8'h05, 1'b0, {2'b01, 8'h00});
    idle(4);
    chk("post_reset_drain", exp_q.size(), 0);

    // Wait for the sweep instances
    for (int c = 0; c < 60000 && !(g_sweep[0].done && g_sweep[1].done); c++) @(posedge clk);
    chk("sweeps_finished", {31'd0, g_sweep[0].done && g_sweep[1].done}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
